// File: rtl/rc_pulse_decoder_pkg.sv
// Shared widths, switch codes and failsafe constants
// for the RC pulse decoder and its channel front ends.
package rc_pulse_decoder_pkg;

  localparam int REC_VAL_BIT_WIDTH = 8;
  localparam int NUM_CH = 5;
  localparam int NUM_AXES = 4;
  localparam int W_BITS = 12;
  localparam int TO_BITS = 15;

  localparam int CH_THROTTLE = 0;
  localparam int CH_YAW = 1;
  localparam int CH_ROLL = 2;
  localparam int CH_PITCH = 3;
  localparam int CH_AUX = 4;

  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [REC_VAL_BIT_WIDTH-1:0] rec_val_t;
  typedef logic [W_BITS-1:0] width_t;
  typedef logic [TO_BITS-1:0] to_cnt_t;

  typedef enum logic [2:0] {
    SW_LOW  = 3'b001,
    SW_MID  = 3'b010,
    SW_HIGH = 3'b100
  } sw_code_t;

  localparam rec_val_t CENTRE_VAL = 8'd125;
  localparam rec_val_t FULL_VAL = 8'd250;
  localparam width_t SW_LOW_US = 12'd1250;
  localparam width_t SW_HIGH_US = 12'd1750;
  localparam width_t W_SAT = 12'hFFF;

  localparam rec_val_t FS_THROTTLE = 8'd0;
  localparam rec_val_t FS_AXIS = CENTRE_VAL;
  localparam sw_code_t FS_SWITCH = SW_MID;
  localparam rec_val_t [NUM_AXES-1:0] FS_VALS =
    {FS_AXIS, FS_AXIS, FS_AXIS, FS_THROTTLE};

  function automatic rec_val_t map_width(
    width_t w,
    width_t lo,
    width_t hi
  );
    width_t span;
    rec_val_t v;
    span = (w - lo) >> 2;
    if (w <= lo) v = '0;
    else if (w >= hi) v = FULL_VAL;
    else if (span > width_t'(FULL_VAL)) v = FULL_VAL;
    else v = span[REC_VAL_BIT_WIDTH-1:0];
    return v;
  endfunction

  function automatic sw_code_t decode_switch(width_t w);
    sw_code_t c;
    unique case (1'b1)
      (w < SW_LOW_US):  c = SW_LOW;
      (w > SW_HIGH_US): c = SW_HIGH;
      default:          c = SW_MID;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rc_pulse_decoder_channel.sv
// One PWM input: synchronizer, edge detect, width measurement,
// glitch filter, arming and loss-of-signal timeout.
module rc_pulse_channel
  import rc_pulse_decoder_pkg::*;
#(
  parameter int GLITCH_MIN_US = 800,
  parameter int GLITCH_MAX_US = 2200,
  parameter int TIMEOUT_US = 30000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   pwm,
  output width_t accepted_width,
  output logic   accept_strobe,
  output logic   timeout_strobe
);

  localparam width_t GMIN = width_t'(GLITCH_MIN_US);
  localparam width_t GMAX = width_t'(GLITCH_MAX_US);
  localparam to_cnt_t TO_LAST = to_cnt_t'(TIMEOUT_US - 1);

  logic    sync1_q, sync1_d;
  logic    sync2_q, sync2_d;
  logic    level_q, level_d;
  logic    armed_q, armed_d;
  width_t  width_q, width_d;
  width_t  acc_width_q, acc_width_d;
  logic    acc_q, acc_d;
  to_cnt_t to_cnt_q, to_cnt_d;
  logic    tmo_q, tmo_d;
  logic    rise, fall, ok;

  always_comb begin
    sync1_d = pwm;
    sync2_d = sync1_q;
    level_d = sync2_q;
    rise = sync2_q & ~level_q;
    fall = ~sync2_q & level_q;

    width_d = width_q;
    if (rise) width_d = width_t'(1);
    else if (sync2_q && width_q != W_SAT)
      width_d = width_q + width_t'(1);

    armed_d = armed_q | rise;
    ok = fall && armed_q &&
         width_q >= GMIN && width_q <= GMAX;
    acc_d = ok;
    acc_width_d = ok ? width_q : acc_width_q;

    tmo_d = FALSE;
    to_cnt_d = to_cnt_q + to_cnt_t'(1);
    if (ok) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      to_cnt_d = '0;
      tmo_d = TRUE;
    end
  end

  // Sync chain resets high so a line already high at release
  // shows no rising edge and cannot arm the channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= TRUE;
      sync2_q <= TRUE;
      level_q <= TRUE;
      armed_q <= FALSE;
      width_q <= '0;
      acc_width_q <= '0;
      acc_q <= FALSE;
      to_cnt_q <= '0;
      tmo_q <= FALSE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      armed_q <= armed_d;
      width_q <= width_d;
      acc_width_q <= acc_width_d;
      acc_q <= acc_d;
      to_cnt_q <= to_cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign accepted_width = acc_width_q;
  assign accept_strobe = acc_q;
  assign timeout_strobe = tmo_q;

endmodule

// File: rtl/rc_pulse_decoder.sv
// Five-channel RC receiver front end: maps pulse widths to
// targets, assembles coherent frames and handles failsafe.
module rc_pulse_decoder
  import rc_pulse_decoder_pkg::*;
#(
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int GLITCH_MIN_US = 800,
  parameter int GLITCH_MAX_US = 2200,
  parameter int TIMEOUT_US = 30000
) (
  input  logic       us_clk,
  input  logic       reset,
  input  logic       throttle_pwm,
  input  logic       yaw_pwm,
  input  logic       roll_pwm,
  input  logic       pitch_pwm,
  input  logic       aux1_pwm,
  output logic [7:0] throttle_val,
  output logic [7:0] yaw_val,
  output logic [7:0] roll_val,
  output logic [7:0] pitch_val,
  output logic [2:0] switch_a,
  output logic       start_signal,
  output logic       signal_lost
);

  localparam width_t LO = width_t'(MIN_US);
  localparam width_t HI = width_t'(MAX_US);

  logic [NUM_CH-1:0]   pwm_vec, acc_vec, to_vec;
  width_t [NUM_CH-1:0] width_vec;

  assign pwm_vec = {aux1_pwm, pitch_pwm, roll_pwm,
                    yaw_pwm, throttle_pwm};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rc_pulse_channel #(
      .GLITCH_MIN_US(GLITCH_MIN_US),
      .GLITCH_MAX_US(GLITCH_MAX_US),
      .TIMEOUT_US(TIMEOUT_US)
    ) u_ch (
      .clk(us_clk),
      .reset(reset),
      .pwm(pwm_vec[g]),
      .accepted_width(width_vec[g]),
      .accept_strobe(acc_vec[g]),
      .timeout_strobe(to_vec[g])
    );
  end

  rec_val_t [NUM_AXES-1:0] hold_q, hold_d;
  rec_val_t [NUM_AXES-1:0] val_q, val_d;
  sw_code_t          sw_hold_q, sw_hold_d;
  sw_code_t          sw_q, sw_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic              start_q, start_d;
  logic              pend_q, pend_d;
  logic              lost_q, lost_d;
  logic              evt;

  always_comb begin
    hold_d = hold_q;
    sw_hold_d = sw_hold_q;
    val_d = val_q;
    sw_d = sw_q;
    lost_d = lost_q;
    mask_d = mask_q | acc_vec;
    evt = FALSE;

    for (int i = 0; i < NUM_AXES; i++)
      if (acc_vec[i])
        hold_d[i] = map_width(width_vec[i], LO, HI);
    if (acc_vec[CH_AUX])
      sw_hold_d = decode_switch(width_vec[CH_AUX]);

    // Timeout outranks a frame completing in the same cycle.
    if (|to_vec) begin
      val_d = FS_VALS;
      sw_d = FS_SWITCH;
      lost_d = TRUE;
      mask_d = '0;
      evt = TRUE;
    end else if (&mask_d) begin
      val_d = hold_d;
      sw_d = sw_hold_d;
      lost_d = FALSE;
      mask_d = '0;
      evt = TRUE;
    end

    // An event right behind a strobe is deferred one cycle.
    start_d = (evt | pend_q) & ~start_q;
    pend_d = (evt | pend_q) & start_q;
  end

  always_ff @(posedge us_clk) begin
    if (reset) begin
      hold_q <= FS_VALS;
      sw_hold_q <= FS_SWITCH;
      val_q <= FS_VALS;
      sw_q <= FS_SWITCH;
      mask_q <= '0;
      start_q <= FALSE;
      pend_q <= FALSE;
      lost_q <= TRUE;
    end else begin
      hold_q <= hold_d;
      sw_hold_q <= sw_hold_d;
      val_q <= val_d;
      sw_q <= sw_d;
      mask_q <= mask_d;
      start_q <= start_d;
      pend_q <= pend_d;
      lost_q <= lost_d;
    end
  end

  assign throttle_val = val_q[CH_THROTTLE];
  assign yaw_val = val_q[CH_YAW];
  assign roll_val = val_q[CH_ROLL];
  assign pitch_val = val_q[CH_PITCH];
  assign switch_a = sw_q;
  assign start_signal = start_q;
  assign signal_lost = lost_q;

endmodule

// File: doc/rc_pulse_decoder.md
# rc_pulse_decoder

Receiver front end for the flight-control chain. It measures five RC PWM pulse trains (throttle, yaw, roll, pitch, aux switch) on the 1 MHz microsecond clock and maps each pulse width to the 8-bit 0–250 target scale. It publishes a coherent frame of targets plus a 3-bit switch code, then issues the one-cycle start strobe consumed by the angle controller. Loss of signal forces failsafe targets.

## Interface
Parameters:
- MIN_US, 1000: pulse width mapped to 0
- MAX_US, 2000: pulse width mapped to 250
- GLITCH_MIN_US, 800: pulses shorter than this are discarded
- GLITCH_MAX_US, 2200: pulses longer than this are discarded
- TIMEOUT_US, 30000: cycles without an accepted pulse before a channel is declared lost

Ports:
- us_clk  in  1  1 MHz clock; one cycle = 1 µs
- reset  in  1  synchronous, active-high
- throttle_pwm, yaw_pwm, roll_pwm, pitch_pwm, aux1_pwm  in  1 each  raw asynchronous receiver pulses
- throttle_val, yaw_val, roll_val, pitch_val  out  8 each  mapped targets, 0–250, 125 = centre
- switch_a  out  3  aux position, one-hot: 001 low (<1250 µs), 010 mid, 100 high (>1750 µs)
- start_signal  out  1  one-cycle frame strobe to the downstream controller
- signal_lost  out  1  high while in failsafe

## Operation
- Per channel:
  - 2-flop synchronizer, then rising/falling edge detect on the synchronized signal.
  - A 12-bit width counter clears on a rising edge and counts every cycle the synchronized level is high. It saturates at 4095.
  - On a falling edge, width w is accepted only if GLITCH_MIN_US ≤ w ≤ GLITCH_MAX_US and the channel is armed.
  - The channel arms at its first rising edge after reset. A pulse already high at reset release is ignored.
- Mapping of an accepted width:
  - w ≤ MIN_US → 0
  - w ≥ MAX_US → 250
  - otherwise (w − MIN_US) >> 2, clamped to 250
  - All arithmetic is unsigned, 12-bit.
- Switch thresholds: w < 1250 → 001; w > 1750 → 100; otherwise 010.
- Frame assembly:
  - Each accepted pulse stores its mapped value in a holding register and sets that channel's bit in a 5-bit fresh mask.
  - A repeated pulse on the same channel overwrites the held value (newest wins).
  - When the mask is all ones, all five holding registers copy to the outputs together. In that same cycle start_signal = 1, the mask clears, and signal_lost clears.
- Timeout:
  - Each channel has a 15-bit timeout counter. It clears on an accepted pulse and otherwise increments.
  - When any counter reaches TIMEOUT_US:
    - Failsafe values are driven: throttle 0; yaw/roll/pitch 125; switch_a 010.
    - signal_lost = 1, start_signal pulses once, and the mask clears.
    - The counter that expired restarts from 0, so start_signal repeats every TIMEOUT_US while the channel stays silent.
- Simultaneous events: if a frame completes in the same cycle another channel times out, the timeout wins. Outputs take failsafe values and the frame is discarded.
- Reset values: throttle_val 0; yaw/roll/pitch_val 125; switch_a 010; start_signal 0; signal_lost 1. Reset also clears all counters and the mask and disarms every channel.

## Timing
- Latency from raw falling edge of the frame-completing channel to start_signal: exactly 4 cycles (2 sync, 1 edge/accept, 1 frame latch). Outputs change in the start_signal cycle.
- start_signal is never high for two consecutive cycles.
- Minimum spacing between strobes is set by the pulse period.
- A clock-aligned pulse held high for N raw cycles measures w = N.
- Reset asserted mid-pulse discards the measurement. Outputs return to reset values on the next edge.

## Structure
- Shared package/defines: REC_VAL_BIT_WIDTH (8), centre value 125, switch codes (001/010/100), failsafe constants, TRUE/FALSE.
- Sub-module rc_pulse_channel: synchronizer, edge detect, width counter, glitch filter, arming, timeout counter. It outputs accepted_width, accept_strobe and timeout_strobe.
- The top level instantiates five of these and holds the mapping, switch decode, frame mask and output registers.

## Test plan
- All channels 1500 µs, 20 ms period → vals 125, switch 010, one start_signal per frame, 4 cycles after the last falling edge; signal_lost falls on the first frame.
- Throttle 900 µs, roll 2100 µs, pitch 1004 µs, yaw 1999 µs, aux 1200 µs → 0, 250, 1, 249, switch 001.
- 500 µs glitch on yaw, then a valid 1600 µs pulse → glitch ignored, yaw_val 150, frame waits for yaw.
- Stop pitch after a good frame → 30000 cycles after its last accepted pulse: signal_lost = 1, throttle 0, others 125, start_signal; repeats every 30000 cycles; clears on the next full frame.
- Reset asserted while throttle is high, released mid-pulse → that pulse ignored; first frame uses the following pulse; outputs hold reset values until then.
- Roll pulses twice before aux completes (1300 then 1700 µs) → roll_val 175 in the frame.
